// File: rtl/debouncer_pkg.sv
// Shared io_circuits constants: default sample/qualify counts for the
// 125 MHz board clock and a counter-width helper used by the debouncer
// and by other slow-sampled IO blocks.
package debouncer_pkg;

  // 25000 cycles = 200 us between samples at 125 MHz.
  localparam int SAMPLE_COUNT_MAX = 25000;
  // 150 consecutive high samples = 30 ms of stable level.
  localparam int PULSE_COUNT_MAX  = 150;

  // Bits needed to count 0..n-1, never less than one so that a
  // degenerate count of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_pulse_gen.sv
// Free-running divider producing a one-cycle sample strobe every
// sample_count_max clocks. Shared by slow-sampled IO filters.
module sample_pulse_gen
  import debouncer_pkg::*;
#(
  parameter int sample_count_max = SAMPLE_COUNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_pulse
);

  localparam int             CW   = cnt_width(sample_count_max);
  localparam logic [CW-1:0] LAST = CW'(sample_count_max - 1);

  logic [CW-1:0] count;

  // Count 0..sample_count_max-1 and wrap; a max of 1 pins count at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, so readers elsewhere never see a half-updated state.
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Decoded straight from the counter register: one cycle per period.
  assign sample_pulse = (count == LAST);

endmodule

// File: rtl/debouncer.sv
// Debouncer for already-synchronized inputs. All bits share one sample
// strobe; each bit owns a saturating counter of consecutive high samples
// and its output asserts once that count reaches pulse_count_max. A single
// low sample clears the count (no release filtering).
// Optional build macro DEBOUNCER_RISE_PULSE_EN adds rise_pulse, a one-cycle
// strobe on each 0->1 transition of debounced_signal.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int width            = 1,
  parameter int sample_count_max = SAMPLE_COUNT_MAX,
  parameter int pulse_count_max  = PULSE_COUNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] glitchy_signal,
  output logic [width-1:0] debounced_signal
`ifdef DEBOUNCER_RISE_PULSE_EN
  ,
  output logic [width-1:0] rise_pulse
`endif
);

  localparam int             PW   = cnt_width(pulse_count_max + 1);
  localparam logic [PW-1:0] PMAX = PW'(pulse_count_max);

  logic sample_pulse;

  sample_pulse_gen #(
    .sample_count_max(sample_count_max)
  ) u_sample_pulse_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_pulse(sample_pulse)
  );

  for (genvar i = 0; i < width; i++) begin : g_bit
    logic [PW-1:0] sat_count;

    // On each sample: count consecutive highs up to PMAX, clear on a low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sat_count <= '0;
      end else if (sample_pulse) begin
        if (!glitchy_signal[i]) begin
          sat_count <= '0;
        end else if (sat_count != PMAX) begin
          sat_count <= sat_count + PW'(1);
        end
      end
    end

    // NOTE: a pure compare of a register is glitch-free and cannot form a
    // latch; the async reset of sat_count clears the output immediately.
    assign debounced_signal[i] = (sat_count == PMAX);
  end

`ifdef DEBOUNCER_RISE_PULSE_EN
  logic [width-1:0] debounced_q;

  // Remember last cycle's outputs to detect the first high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debounced_q <= '0;
    end else begin
      debounced_q <= debounced_signal;
    end
  end

  assign rise_pulse = debounced_signal & ~debounced_q;
`endif

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Downstream stage of the 2-FF synchronizer in the io_circuits chain: button/switch -> synchronizer -> debouncer -> consumers (edge detection, user logic).
- Filters mechanical bounce on a vector of already-synchronized bits.
- A shared sample-pulse generator samples all bits at a slow rate. Each bit has a saturating counter.
- An output bit goes high only after the input has been high on pulse_count_max consecutive samples.

Parameters:
- width, 1, number of independent bits debounced.
- sample_count_max, 25000, clock cycles between sample pulses (>=1); 25000 = 200 us at 125 MHz.
- pulse_count_max, 150, consecutive high samples required before output asserts (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- glitchy_signal  input  width  synchronized but bouncing inputs (from synchronizer.sync_signal).
- debounced_signal  output  width  filtered outputs.
- rise_pulse  output  width  present only with DEBOUNCER_RISE_PULSE_EN; see Optional Feature.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low immediately clears the sample counter, all saturation counters, debounced_signal and rise_pulse to 0.
  - Reset mid-operation discards all accumulated history.
  - Release is sampled on the next clk edge.
- Sample generator:
  - Counter of width $clog2(sample_count_max) bits, min 1.
  - Counts 0..sample_count_max-1 and wraps to 0.
  - sample_pulse is high for exactly one cycle when count == sample_count_max-1.
  - First pulse occurs in cycle sample_count_max after reset release.
  - sample_count_max=1 gives a pulse every cycle.
- Per-bit saturating counter: width $clog2(pulse_count_max+1). Updates only on cycles with sample_pulse.
  - glitchy_signal[i]=1: increment; hold at pulse_count_max (no wrap).
  - glitchy_signal[i]=0: clear to 0.
  - No sample_pulse: hold. Input activity between pulses is ignored entirely.
- Output:
  - debounced_signal[i] = (counter[i] == pulse_count_max), decoded from a register, so it is glitch-free.
  - Assertion latency: output goes high in the cycle after the pulse_count_max-th consecutive high sample.
  - Deassertion: the first low sample clears the counter, and the output falls in the following cycle. There is no release filtering by design.
- Bits are fully independent: simultaneous transitions on different bits do not interact.
- Boundary behaviour: an input held high indefinitely leaves the counter saturated and the output stays high. A single low sample at any point restarts the count from 0.

Optional Feature:
- Macro: DEBOUNCER_RISE_PULSE_EN.
- Defined:
  - Adds port rise_pulse[width-1:0] and a width-bit register holding the previous debounced_signal.
  - rise_pulse[i] is high for exactly one cycle, the same cycle debounced_signal[i] first reads 1 after being 0.
  - rise_pulse is 0 during reset and on the first cycle after release.
- Undefined: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Shared io_circuits constants header:
  - Default SAMPLE_COUNT_MAX and PULSE_COUNT_MAX values for the board clock.
  - Counter-width helper ($clog2 wrappers, min-1 guard).
- One natural sub-module: sample_pulse_gen (parameter sample_count_max; ports clk, rst_n, sample_pulse). It is reusable by other slow-sampled IO blocks.
- The per-bit saturating counters stay in a generate loop in debouncer.

Test Plan (width=2, sample_count_max=4, pulse_count_max=3 unless noted):
- Reset/idle:
  - Stimulus: hold rst_n low 5 cycles, then release with inputs 0.
  - Expect: sample_pulse first high at cycle 4 after release, then every 4 cycles; debounced_signal stays 2'b00.
- Clean press:
  - Stimulus: glitchy_signal[0]=1 held from reset release.
  - Expect: debounced_signal[0] rises the cycle after the 3rd sample pulse (cycle 13) and stays high while held; bit 1 stays 0.
- Bounce:
  - Stimulus: bit 0 high for samples 1-2, low at sample 3, then high for samples 4-6.
  - Expect: no assertion until the cycle after sample 6 (cycle 25).
- Between-sample glitch:
  - Stimulus: once debounced_signal[0]=1, drive a 2-cycle low pulse that does not overlap any sample pulse.
  - Expect: output remains 1.
- Release and mid-operation reset:
  - Stimulus: low sample while bit 0 is asserted.
  - Expect: output 0 on the next cycle.
  - Stimulus: assert rst_n asynchronously (off clock edge) while counters are saturated.
  - Expect: outputs 0 immediately, and a full 3-sample qualification is required again afterwards.
- With DEBOUNCER_RISE_PULSE_EN: run the clean-press scenario.
  - Expect: rise_pulse[0] is high for exactly 1 cycle (cycle 13) and stays 0 while held.
  - Repeat the press after release: expect exactly one pulse again.
